// File: rtl/data_cache_pkg.sv
// Shared geometry defaults and FSM state encoding for the direct-mapped data cache.
package data_cache_pkg;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 4;

    typedef enum logic [1:0] {
        READY      = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } cache_state_t;
endpackage

// File: rtl/data_cache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache; one line per set.
module cache_line_array #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_W         = 30 - LINE_ADDR_LEN - SET_ADDR_LEN,
    parameter int LINE_W        = 32 << LINE_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  i_idx,
    output logic                     o_valid,
    output logic                     o_dirty,
    output logic [TAG_W-1:0]         o_tag,
    output logic [LINE_W-1:0]        o_line,
    input  logic                     i_wr_en,
    input  logic [LINE_ADDR_LEN-1:0] i_wr_word,
    input  logic [3:0]               i_wr_be,
    input  logic [31:0]              i_wr_data,
    input  logic                     i_fill_en,
    input  logic [TAG_W-1:0]         i_fill_tag,
    input  logic [LINE_W-1:0]        i_fill_line
);
    localparam int SETS = 1 << SET_ADDR_LEN;

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_fill_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_be[b])
                    r_data[i_idx][32*i_wr_word + 8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache with zero-latency hits and a line-swap FSM.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             read_request,
    input  logic                             write_request,
    input  logic [3:0]                       write_type,
    input  logic [31:0]                      address,
    input  logic [31:0]                      write_data,
    output logic [31:0]                      read_data,
    output logic                             miss,
    output logic                             cache_request_finish,
    output logic                             mem_read_request,
    output logic                             mem_write_request,
    output logic [31:0]                      mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]   mem_write_data,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]   mem_read_data,
    input  logic                             mem_request_finish
);
    localparam int LINE_W = 32 << LINE_ADDR_LEN;
    localparam int OFF_W  = LINE_ADDR_LEN + 2;
    localparam int TAG_W  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;

    cache_state_t              r_state, w_next;
    logic [TAG_W-1:0]          w_tag, r_miss_tag, w_arr_tag;
    logic [SET_ADDR_LEN-1:0]   w_set, r_miss_set, w_idx;
    logic [LINE_ADDR_LEN-1:0]  w_word;
    logic [LINE_W-1:0]         w_arr_line, r_fill_line;
    logic                      w_arr_valid, w_arr_dirty;
    logic                      w_req, w_hit, w_fill;

    assign w_tag  = address[31 -: TAG_W];
    assign w_set  = address[OFF_W +: SET_ADDR_LEN];
    assign w_word = address[2 +: LINE_ADDR_LEN];
    // Outside READY the array is pointed at the set latched when the miss began.
    assign w_idx  = (r_state == READY) ? w_set : r_miss_set;

    assign w_req = read_request | write_request;
    assign w_hit = w_arr_valid && (w_arr_tag == w_tag) && (r_state == READY);

    assign miss                 = w_req & ~w_hit;
    assign cache_request_finish = w_req & w_hit;
    // A simultaneous read and write is a write, so no load data is returned.
    assign read_data      = (read_request && !write_request && w_hit) ?
                            w_arr_line[32*w_word +: 32] : 32'd0;
    assign mem_write_data = w_arr_line;

    cache_line_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_W         (TAG_W),
        .LINE_W        (LINE_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (w_idx),
        .o_valid     (w_arr_valid),
        .o_dirty     (w_arr_dirty),
        .o_tag       (w_arr_tag),
        .o_line      (w_arr_line),
        .i_wr_en     (write_request & w_hit),
        .i_wr_word   (w_word),
        .i_wr_be     (write_type),
        .i_wr_data   (write_data),
        .i_fill_en   (w_fill),
        .i_fill_tag  (r_miss_tag),
        .i_fill_line (r_fill_line)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= READY;
        else     r_state <= w_next;
    end

    // Latching the missing tag/set lets the swap finish even if the request drops.
    always_ff @(posedge clk) begin
        if (r_state == READY && miss) begin
            r_miss_tag <= w_tag;
            r_miss_set <= w_set;
        end
        if (r_state == SWAP_IN && mem_request_finish)
            r_fill_line <= mem_read_data;
    end

    always_comb begin
        w_next            = r_state;
        mem_read_request  = 1'b0;
        mem_write_request = 1'b0;
        mem_addr          = '0;
        w_fill            = 1'b0;
        case (r_state)
            READY: begin
                if (miss)
                    w_next = (w_arr_valid && w_arr_dirty) ? SWAP_OUT : SWAP_IN;
            end
            SWAP_OUT: begin
                mem_write_request = 1'b1;
                mem_addr          = {w_arr_tag, r_miss_set, {OFF_W{1'b0}}};
                if (mem_request_finish) w_next = SWAP_IN;
            end
            SWAP_IN: begin
                mem_read_request = 1'b1;
                mem_addr         = {r_miss_tag, r_miss_set, {OFF_W{1'b0}}};
                if (mem_request_finish) w_next = SWAP_IN_OK;
            end
            SWAP_IN_OK: begin
                w_fill = 1'b1;
                w_next = READY;
            end
            default: w_next = READY;
        endcase
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against a word-level cache/memory model.
module tb_data_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic         read_request, write_request;
    logic [3:0]   write_type;
    logic [31:0]  address, write_data;
    logic [31:0]  read_data;
    logic         miss, cache_request_finish;
    logic         mem_read_request, mem_write_request;
    logic [31:0]  mem_addr;
    logic [255:0] mem_write_data, mem_read_data;
    logic         mem_request_finish;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-set line state plus a backing memory keyed by line address.
    bit           mvalid [16];
    bit           mdirty [16];
    logic [22:0]  mtag   [16];
    logic [255:0] mdata  [16];
    logic [255:0] mem    [logic [31:0]];

    data_cache dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_request         (read_request),
        .write_request        (write_request),
        .write_type           (write_type),
        .address              (address),
        .write_data           (write_data),
        .read_data            (read_data),
        .miss                 (miss),
        .cache_request_finish (cache_request_finish),
        .mem_read_request     (mem_read_request),
        .mem_write_request    (mem_write_request),
        .mem_addr             (mem_addr),
        .mem_write_data       (mem_write_data),
        .mem_read_data        (mem_read_data),
        .mem_request_finish   (mem_request_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] memline(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = (la ^ 32'h5A00_0000) + i;
        return l;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
    endtask

    // One request from first drive until its hit cycle; memory side answers after dly cycles.
    task automatic access(input logic rd, input logic wr, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd, input int dly);
        int s, w, nfin;
        logic [22:0]  t;
        logic [31:0]  va, la;
        logic [255:0] line;
        bit hit;
        s = int'(addr[8:5]);
        w = int'(addr[4:2]);
        t = addr[31:9];
        la = {addr[31:5], 5'b0};
        nfin = 0;
        read_request = rd; write_request = wr; write_type = be;
        address = addr; write_data = wd;
        #1;
        hit = mvalid[s] && (mtag[s] == t);
        if (!hit) begin
            chk("miss_first", miss, 1);
            nfin += int'(cache_request_finish);
            if (mvalid[s] && mdirty[s]) begin
                va = {mtag[s], addr[8:5], 5'b0};
                @(posedge clk); #2;
                for (int i = 0; i < dly; i++) begin
                    chk("wb_hold_wr", mem_write_request, 1);
                    chk("wb_hold_miss", miss, 1);
                    nfin += int'(cache_request_finish);
                    @(posedge clk); #2;
                end
                chk("wb_wr_req", mem_write_request, 1);
                chk("wb_rd_req", mem_read_request, 0);
                chk("wb_addr", mem_addr, va);
                chk("wb_data", mem_write_data, mdata[s]);
                nfin += int'(cache_request_finish);
                mem[va] = mdata[s];
                mem_request_finish = 1;
                @(posedge clk); #1;
                mem_request_finish = 0;
                #1;
            end else begin
                @(posedge clk); #2;
            end
            for (int i = 0; i < dly; i++) begin
                chk("rf_hold_rd", mem_read_request, 1);
                chk("rf_hold_miss", miss, 1);
                nfin += int'(cache_request_finish);
                @(posedge clk); #2;
            end
            chk("rf_rd_req", mem_read_request, 1);
            chk("rf_wr_req", mem_write_request, 0);
            chk("rf_addr", mem_addr, la);
            nfin += int'(cache_request_finish);
            line = memline(la);
            mem_read_data = line;
            mem_request_finish = 1;
            @(posedge clk); #1;
            mem_request_finish = 0;
            mem_read_data = '0;
            #1;
            chk("ok_rd_req", mem_read_request, 0);
            chk("ok_wr_req", mem_write_request, 0);
            chk("ok_miss", miss, 1);
            nfin += int'(cache_request_finish);
            @(posedge clk); #2;
            mvalid[s] = 1; mdirty[s] = 0; mtag[s] = t; mdata[s] = line;
        end
        chk("hit_miss", miss, 0);
        nfin += int'(cache_request_finish);
        chk("rdata", read_data, (rd && !wr) ? mdata[s][32*w +: 32] : 32'd0);
        chk("req_finish_once", nfin, 1);
        chk("hit_no_mem", {mem_read_request, mem_write_request}, 0);
        @(posedge clk); #1;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdata[s][32*w + 8*b +: 8] = wd[8*b +: 8];
            mdirty[s] = 1;
        end
        read_request = 0;
        write_request = 0;
    endtask

    initial begin
        logic [255:0] l40;
        rst = 1; read_request = 0; write_request = 0; write_type = 0;
        address = 0; write_data = 0; mem_read_data = 0; mem_request_finish = 0;
        clear_model();
        for (int i = 0; i < 8; i++) l40[32*i +: 32] = 32'h100 + i;
        mem[32'h40] = l40;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_miss", miss, 0);
        chk("rst_mem_rd", mem_read_request, 0);
        chk("rst_mem_wr", mem_write_request, 0);
        chk("rst_finish", cache_request_finish, 0);
        chk("rst_rdata", read_data, 0);
        @(posedge clk); #1;

        // Finish pulses outside a swap are ignored.
        mem_request_finish = 1;
        @(posedge clk); #1;
        mem_request_finish = 0;
        #1;
        chk("idle_fin_ignored", {mem_read_request, mem_write_request, miss}, 0);
        @(posedge clk); #1;

        access(1, 0, 4'h0, 32'h40, 0, 0);
        access(0, 1, 4'hF, 32'h40, 32'h1122_3344, 0);
        access(0, 1, 4'h3, 32'h40, 32'hDEAD_BEEF, 0);
        access(1, 0, 4'h0, 32'h40, 0, 0);
        chk("merge_model", mdata[2][31:0], 32'h1122_BEEF);
        access(1, 0, 4'h0, 32'h240, 0, 2);
        access(1, 1, 4'hC, 32'h244, 32'hCAFE_0000, 0);
        access(1, 0, 4'h0, 32'h244, 0, 0);
        access(1, 0, 4'h0, 32'h440, 0, 10);

        // Reset while a refill is outstanding.
        read_request = 1; address = 32'h88;
        #1 chk("mid_miss", miss, 1);
        @(posedge clk); #1;
        chk("mid_swapin", mem_read_request, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; read_request = 0;
        #1;
        chk("mid_rst_rd_req", mem_read_request, 0);
        chk("mid_rst_miss", miss, 0);
        clear_model();
        @(posedge clk); #1;
        access(1, 0, 4'h0, 32'h440, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic rd, wr;
            a = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'b00};
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1;
            access(rd, wr, 4'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, meaning log2 of words per line (8 words, 256-bit line).
REQ-002 SHALL have parameter SET_ADDR_LEN, default 4, meaning log2 of line count (16 lines, direct-mapped).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port read_request, input, 1 bit, MEM-stage load request.
REQ-006 SHALL have port write_request, input, 1 bit, MEM-stage store request.
REQ-007 SHALL have port write_type, input, 4 bits, byte enables for stores.
REQ-008 SHALL have port address, input, 32 bits, byte address, word-aligned (bits 1:0 ignored).
REQ-009 SHALL have port write_data, input, 32 bits, store data, lanes already aligned.
REQ-010 SHALL have port read_data, output, 32 bits, load result.
REQ-011 SHALL have port miss, output, 1 bit, stall request to the hazard unit.
REQ-012 SHALL have port cache_request_finish, output, 1 bit, request serviced this cycle.
REQ-013 SHALL have ports mem_read_request and mem_write_request, outputs, 1 bit each, line fetch and line writeback to the data bus.
REQ-014 SHALL have port mem_addr, output, 32 bits, line-aligned (low LINE_ADDR_LEN+2 bits zero).
REQ-015 SHALL have port mem_write_data, output, 256 bits, victim line.
REQ-016 SHALL have port mem_read_data, input, 256 bits, refill line.
REQ-017 SHALL have port mem_request_finish, input, 1 bit, one-cycle completion pulse from the data bus.

Function
REQ-018 SHALL split address into tag [31:9], set [8:5], word [4:2] at default parameters; tag width = 30-LINE_ADDR_LEN-SET_ADDR_LEN.
REQ-019 SHALL define hit = valid[set] and tag[set]==addr tag and state==READY.
REQ-020 SHALL define request = read_request | write_request; if both are high, SHALL treat it as a write.
REQ-021 SHALL drive miss = request & ~hit combinationally, and cache_request_finish = request & hit.
REQ-022 SHALL return read_data combinationally on a read hit (zero latency), else 0.
REQ-023 SHALL, on a write hit, update only enabled bytes at the clock edge and set dirty[set].
REQ-024 SHALL implement FSM states READY, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
REQ-025 SHALL, in READY on miss, go to SWAP_OUT if victim valid and dirty, else SWAP_IN.
REQ-026 SHALL, in SWAP_OUT, hold mem_write_request=1 with mem_addr = {victim tag, set, 0} and mem_write_data = victim line until mem_request_finish, then go to SWAP_IN.
REQ-027 SHALL, in SWAP_IN, hold mem_read_request=1 with mem_addr = {addr tag, set, 0} until mem_request_finish, latch mem_read_data, then go to SWAP_IN_OK.
REQ-028 SHALL, in SWAP_IN_OK, write the latched line, set valid, clear dirty, load the tag, and return to READY; the retried access hits the next cycle.
REQ-029 SHALL never assert mem_read_request and mem_write_request together; both SHALL be 0 in READY and SWAP_IN_OK.
REQ-030 SHALL ignore mem_request_finish in READY and SWAP_IN_OK.
REQ-031 SHALL complete an in-flight swap even if request drops mid-miss.
REQ-032 SHALL give a miss a minimum penalty of 3 cycles (clean victim, finish in first SWAP_IN cycle) and 4 cycles (dirty victim).

Reset
REQ-033 SHALL, when rst is high at an edge (including mid-swap), enter READY and clear all valid and dirty bits; data and tag contents are don't-care.
REQ-034 SHALL hold outputs after reset at: miss=0 (with no request), mem_read_request=0, mem_write_request=0, cache_request_finish=0, read_data=0.

Structure
REQ-035 SHALL take LINE_ADDR_LEN, SET_ADDR_LEN and the FSM state encodings from the shared defines include file.
REQ-036 SHALL place valid/dirty/tag/data storage in one sub-module, cache_line_array; the FSM and hit logic stay in data_cache.

Verification
REQ-037 SHALL pass cold read: after reset, read 0x0000_0040 with memory line = word i is 0x100+i. Required: miss=1; clean SWAP_IN; read_data=0x100 on the hit cycle.
REQ-038 SHALL pass write hit: write 0xDEADBEEF, write_type 4'b0011, to a hit word holding 0x11223344. Required: later read returns 0x1122BEEF; dirty set; no mem traffic.
REQ-039 SHALL pass dirty eviction: dirty line at 0x40, then read 0x240 (same set). Required: SWAP_OUT with mem_addr=0x40 carrying the modified line, then SWAP_IN with mem_addr=0x240.
REQ-040 SHALL pass simultaneous read and write request. Required: handled as a write; bytes written; dirty set.
REQ-041 SHALL pass reset mid-SWAP_IN. Required: mem_read_request=0 the next cycle; prior hit address now misses.
REQ-042 SHALL pass delayed finish: mem_request_finish arrives 10 cycles late. Required: miss held high for the whole wait; cache_request_finish pulses exactly once per request.
